// File: rtl/regfile_port_arbiter.sv
// Shares one register-file port between two requesters over valid/ready, sequencing rf enables and read responses.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); the default build arbitrates round-robin.
module regfile_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr_a,
  input  logic [2*ADDR_W-1:0] req_addr_b,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata_a,
  output logic [DATA_W-1:0]   rsp_rdata_b,
  output logic [ADDR_W-1:0]   rf_read1,
  output logic [ADDR_W-1:0]   rf_read2,
  output logic [ADDR_W-1:0]   rf_write,
  output logic                rf_re,
  output logic                rf_we,
  output logic [DATA_W-1:0]   rf_data,
  input  logic [DATA_W-1:0]   rf_readout1,
  input  logic [DATA_W-1:0]   rf_readout2
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
  logic [ADDR_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, wr_q, wr_d;
  logic                re_q, re_d, we_q, we_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          grant;
  logic                accept;
  logic                win;

  always_comb begin
    grant = 2'b00;
`ifdef ARB_FIXED_PRIO_EN
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
`else
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
`endif
  end

  // Ready is withheld during reset so a request held across reset is never taken.
  assign req_ready = (state_q == IDLE && !reset) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign win       = req_ready[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 2'b00;
    rsp_a_d      = rsp_a_q;
    rsp_b_d      = rsp_b_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    wr_d         = wr_q;
    data_d       = data_q;
    re_d         = 1'b0;
    we_d         = 1'b0;
    case (state_q)
      IDLE: begin
        // rf_* are loaded at acceptance so they are presented during the ISSUE cycle.
        if (accept) begin
          owner_d      = win;
          last_grant_d = win;
          state_d      = ISSUE;
          if (req_we[win]) begin
            we_d   = 1'b1;
            wr_d   = win ? req_addr_a[2*ADDR_W-1:ADDR_W] : req_addr_a[ADDR_W-1:0];
            data_d = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          end else begin
            re_d  = 1'b1;
            rd1_d = win ? req_addr_a[2*ADDR_W-1:ADDR_W] : req_addr_a[ADDR_W-1:0];
            rd2_d = win ? req_addr_b[2*ADDR_W-1:ADDR_W] : req_addr_b[ADDR_W-1:0];
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? IDLE : WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_a_d     = rf_readout1;
          rsp_b_d     = rf_readout2;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 2'd0;
      rsp_valid_q  <= 2'b00;
      rsp_a_q      <= '0;
      rsp_b_q      <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      wr_q         <= '0;
      data_q       <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_a_q      <= rsp_a_d;
      rsp_b_q      <= rsp_b_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      re_q         <= re_d;
      we_q         <= we_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata_a = rsp_a_q;
  assign rsp_rdata_b = rsp_b_q;
  assign rf_read1    = rd1_q;
  assign rf_read2    = rd2_q;
  assign rf_write    = wr_q;
  assign rf_re       = re_q;
  assign rf_we       = we_q;
  assign rf_data     = data_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: unit A uses RD_LAT=1, unit B uses RD_LAT=3, each with a register-file model.
module tb_regfile_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Unit A (RD_LAT = 1)
  logic [1:0]  a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [7:0]  a_addr_a, a_addr_b;
  logic [31:0] a_wdata;
  logic [15:0] a_rsp_a, a_rsp_b, a_rf_data, a_ro1, a_ro2;
  logic [3:0]  a_rd1, a_rd2, a_wr;
  logic        a_re, a_we;

  // Unit B (RD_LAT = 3)
  logic [1:0]  b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [7:0]  b_addr_a, b_addr_b;
  logic [31:0] b_wdata;
  logic [15:0] b_rsp_a, b_rsp_b, b_rf_data, b_ro1, b_ro2;
  logic [3:0]  b_rd1, b_rd2, b_wr;
  logic        b_re, b_we;

  regfile_port_arbiter #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr_a(a_addr_a), .req_addr_b(a_addr_b), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata_a(a_rsp_a), .rsp_rdata_b(a_rsp_b),
    .rf_read1(a_rd1), .rf_read2(a_rd2), .rf_write(a_wr),
    .rf_re(a_re), .rf_we(a_we), .rf_data(a_rf_data),
    .rf_readout1(a_ro1), .rf_readout2(a_ro2)
  );

  regfile_port_arbiter #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr_a(b_addr_a), .req_addr_b(b_addr_b), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata_a(b_rsp_a), .rsp_rdata_b(b_rsp_b),
    .rf_read1(b_rd1), .rf_read2(b_rd2), .rf_write(b_wr),
    .rf_re(b_re), .rf_we(b_we), .rf_data(b_rf_data),
    .rf_readout1(b_ro1), .rf_readout2(b_ro2)
  );

  // Register-file models: one-cycle read for A, three-cycle read pipeline for B.
  logic [15:0] mem_a [16] = '{default: 16'h0000};
  logic [15:0] mem_b [16] = '{2: 16'h00AA, 3: 16'h0055, default: 16'h0000};
  logic [15:0] b_s1a = '0, b_s1b = '0, b_s2a = '0, b_s2b = '0, b_s3a = '0, b_s3b = '0;
  logic [15:0] a_o1 = '0, a_o2 = '0;

  always @(posedge clk) begin
    if (a_we) mem_a[a_wr] <= a_rf_data;
    if (a_re) begin
      a_o1 <= mem_a[a_rd1];
      a_o2 <= mem_a[a_rd2];
    end
    if (b_we) mem_b[b_wr] <= b_rf_data;
    if (b_re) begin
      b_s1a <= mem_b[b_rd1];
      b_s1b <= mem_b[b_rd2];
    end
    b_s2a <= b_s1a; b_s2b <= b_s1b;
    b_s3a <= b_s2a; b_s3b <= b_s2b;
  end
  assign a_ro1 = a_o1;
  assign a_ro2 = a_o2;
  assign b_ro1 = b_s3a;
  assign b_ro2 = b_s3b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_req_valid = 2'b11; a_req_we = 2'b00;
    b_req_valid = 2'b11; b_req_we = 2'b00;
    step(); step(); step();
    #1;
    n_cmp++; if (a_req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready_a got=%b exp=00", a_req_ready); end
    n_cmp++; if (b_req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready_b got=%b exp=00", b_req_ready); end
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid got=%b exp=00", a_rsp_valid); end
    n_cmp++; if ({a_re, a_we} !== 2'b00) begin n_bad++; $display("FAIL rst_re_we got=%b exp=00", {a_re, a_we}); end
    n_cmp++; if ({a_rd1, a_rd2, a_wr} !== 12'h000) begin n_bad++; $display("FAIL rst_idx got=%h exp=000", {a_rd1, a_rd2, a_wr}); end
    n_cmp++; if ({a_rf_data, a_rsp_a, a_rsp_b} !== 48'h0) begin n_bad++; $display("FAIL rst_data got=%h exp=0", {a_rf_data, a_rsp_a, a_rsp_b}); end
    a_req_valid = 2'b00; b_req_valid = 2'b00;
    step();
    reset = 1'b0;
  endtask

  // Requester 1 writes reg6=143, then requester 0 reads a=6, b=3.
  task automatic test_write_read();
    step();
    a_req_valid = 2'b10; a_req_we = 2'b10; a_addr_a = {4'd6, 4'd0}; a_wdata = {16'd143, 16'd0};
    #1;
    n_cmp++; if (a_req_ready !== 2'b10) begin n_bad++; $display("FAIL wr_ready got=%b exp=10", a_req_ready); end
    step();
    a_req_valid = 2'b00;
    n_cmp++; if ({a_we, a_re} !== 2'b10) begin n_bad++; $display("FAIL wr_issue_we_re got=%b exp=10", {a_we, a_re}); end
    n_cmp++; if (a_wr !== 4'd6 || a_rf_data !== 16'd143) begin n_bad++; $display("FAIL wr_issue_addr_data got=%0d/%0d exp=6/143", a_wr, a_rf_data); end
    step();
    n_cmp++; if (a_we !== 1'b0) begin n_bad++; $display("FAIL wr_we_one_cycle got=%b exp=0", a_we); end
    a_req_valid = 2'b01; a_req_we = 2'b00; a_addr_a = {4'd0, 4'd6}; a_addr_b = {4'd0, 4'd3};
    #1;
    n_cmp++; if (a_req_ready !== 2'b01) begin n_bad++; $display("FAIL rd_ready got=%b exp=01", a_req_ready); end
    step();
    a_req_valid = 2'b00;
    n_cmp++; if ({a_re, a_we} !== 2'b10 || a_rd1 !== 4'd6 || a_rd2 !== 4'd3)
      begin n_bad++; $display("FAIL rd_issue got=re%b we%b %0d/%0d exp=re1 we0 6/3", a_re, a_we, a_rd1, a_rd2); end
    step();
    n_cmp++; if (a_rsp_valid !== 2'b00 || a_re !== 1'b0) begin n_bad++; $display("FAIL rd_wait got=%b re=%b exp=00 re=0", a_rsp_valid, a_re); end
    step();
    n_cmp++; if (a_rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rd_rsp_valid got=%b exp=01", a_rsp_valid); end
    n_cmp++; if (a_rsp_a !== 16'd143 || a_rsp_b !== 16'd0) begin n_bad++; $display("FAIL rd_rsp_data got=%0d/%0d exp=143/0", a_rsp_a, a_rsp_b); end
    step();
    n_cmp++; if (a_rsp_valid !== 2'b00 || a_rsp_a !== 16'd143) begin n_bad++; $display("FAIL rd_rsp_hold got=%b/%0d exp=00/143", a_rsp_valid, a_rsp_a); end
  endtask

  // Both request reads on the first cycle after reset.
  task automatic test_both_reads();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    a_req_valid = 2'b11; a_req_we = 2'b00; a_addr_a = {4'd3, 4'd6}; a_addr_b = {4'd6, 4'd3};
    #1;
    n_cmp++; if (a_req_ready !== 2'b01) begin n_bad++; $display("FAIL both_first_grant got=%b exp=01", a_req_ready); end
    step();
    a_req_valid = 2'b10;
    #1;
    n_cmp++; if (a_req_ready !== 2'b00 || a_re !== 1'b1 || a_rd1 !== 4'd6)
      begin n_bad++; $display("FAIL both_issue0 got=ready%b re%b rd1=%0d exp=ready00 re1 rd1=6", a_req_ready, a_re, a_rd1); end
    step();
    n_cmp++; if (a_req_ready !== 2'b00 || a_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL both_wait0 got=%b/%b exp=00/00", a_req_ready, a_rsp_valid); end
    step();
    n_cmp++; if (a_rsp_valid !== 2'b01 || a_rsp_a !== 16'd143 || a_rsp_b !== 16'd0)
      begin n_bad++; $display("FAIL both_rsp0 got=%b %0d/%0d exp=01 143/0", a_rsp_valid, a_rsp_a, a_rsp_b); end
    n_cmp++; if (a_req_ready !== 2'b10) begin n_bad++; $display("FAIL both_second_grant got=%b exp=10", a_req_ready); end
    step();
    a_req_valid = 2'b00;
    n_cmp++; if (a_rsp_valid !== 2'b00 || a_re !== 1'b1 || a_rd1 !== 4'd3)
      begin n_bad++; $display("FAIL both_issue1 got=%b re%b rd1=%0d exp=00 re1 rd1=3", a_rsp_valid, a_re, a_rd1); end
    step();
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL both_wait1 got=%b exp=00", a_rsp_valid); end
    step();
    n_cmp++; if (a_rsp_valid !== 2'b10 || a_rsp_a !== 16'd0 || a_rsp_b !== 16'd143)
      begin n_bad++; $display("FAIL both_rsp1 got=%b %0d/%0d exp=10 0/143", a_rsp_valid, a_rsp_a, a_rsp_b); end
  endtask

  // Both hold write requests for eight accepts.
  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    logic [3:0] exp_wr;
    logic [15:0] exp_data;
    step();
    a_req_valid = 2'b11; a_req_we = 2'b11;
    a_addr_a = {4'd9, 4'd8}; a_wdata = {16'h0B0B, 16'h0A0A};
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_rdy = 2'b01;
`else
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_wr   = exp_rdy[1] ? 4'd9 : 4'd8;
      exp_data = exp_rdy[1] ? 16'h0B0B : 16'h0A0A;
      #1;
      n_cmp++; if (a_req_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, a_req_ready, exp_rdy); end
      step();
      n_cmp++; if (a_req_ready !== 2'b00 || a_we !== 1'b1 || a_wr !== exp_wr || a_rf_data !== exp_data)
        begin n_bad++; $display("FAIL b2b_issue%0d got=ready%b we%b %0d/%h exp=ready00 we1 %0d/%h", k, a_req_ready, a_we, a_wr, a_rf_data, exp_wr, exp_data); end
      step();
    end
    a_req_valid = 2'b00;
  endtask

  // One-cycle reset during the WAIT of a read, then a fresh read.
  task automatic test_reset_mid();
    step();
    a_req_valid = 2'b01; a_req_we = 2'b00; a_addr_a = {4'd0, 4'd8}; a_addr_b = {4'd0, 4'd9};
    #1;
    n_cmp++; if (a_req_ready !== 2'b01) begin n_bad++; $display("FAIL rmid_ready got=%b exp=01", a_req_ready); end
    step();
    a_req_valid = 2'b00;
    n_cmp++; if (a_re !== 1'b1) begin n_bad++; $display("FAIL rmid_issue got=%b exp=1", a_re); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (a_rsp_valid !== 2'b00 || a_re !== 1'b0 || a_we !== 1'b0)
      begin n_bad++; $display("FAIL rmid_dropped got=%b re%b we%b exp=00 re0 we0", a_rsp_valid, a_re, a_we); end
    a_req_valid = 2'b01; a_addr_a = {4'd0, 4'd8}; a_addr_b = {4'd0, 4'd6};
    #1;
    n_cmp++; if (a_req_ready !== 2'b01) begin n_bad++; $display("FAIL rmid_ready_after got=%b exp=01", a_req_ready); end
    step();
    a_req_valid = 2'b00;
    n_cmp++; if (a_re !== 1'b1 || a_rd1 !== 4'd8 || a_rsp_valid !== 2'b00)
      begin n_bad++; $display("FAIL rmid_issue2 got=re%b %0d %b exp=re1 8 00", a_re, a_rd1, a_rsp_valid); end
    step();
    n_cmp++; if (a_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rmid_wait2 got=%b exp=00", a_rsp_valid); end
    step();
    n_cmp++; if (a_rsp_valid !== 2'b01 || a_rsp_a !== 16'h0A0A || a_rsp_b !== 16'd143)
      begin n_bad++; $display("FAIL rmid_rsp got=%b %h/%0d exp=01 0a0a/143", a_rsp_valid, a_rsp_a, a_rsp_b); end
  endtask

  // Three-cycle register-file latency on unit B.
  task automatic test_rd_lat3();
    step();
    b_req_valid = 2'b01; b_req_we = 2'b00; b_addr_a = {4'd0, 4'd2}; b_addr_b = {4'd0, 4'd3};
    #1;
    n_cmp++; if (b_req_ready !== 2'b01) begin n_bad++; $display("FAIL lat3_ready got=%b exp=01", b_req_ready); end
    for (int k = 1; k <= 6; k++) begin
      step();
      b_req_valid = 2'b00;
      n_cmp++; if (b_rsp_valid !== ((k == 5) ? 2'b01 : 2'b00))
        begin n_bad++; $display("FAIL lat3_rsp_valid_t%0d got=%b exp=%b", k + 1, b_rsp_valid, (k == 5) ? 2'b01 : 2'b00); end
      n_cmp++; if (b_re !== (k == 1) || b_we !== 1'b0)
        begin n_bad++; $display("FAIL lat3_enables_t%0d got=re%b we%b exp=re%b we0", k + 1, b_re, b_we, (k == 1)); end
      if (k == 5) begin
        n_cmp++; if (b_rsp_a !== 16'h00AA || b_rsp_b !== 16'h0055)
          begin n_bad++; $display("FAIL lat3_data got=%h/%h exp=00aa/0055", b_rsp_a, b_rsp_b); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    a_req_valid = '0; a_req_we = '0; a_addr_a = '0; a_addr_b = '0; a_wdata = '0;
    b_req_valid = '0; b_req_we = '0; b_addr_a = '0; b_addr_b = '0; b_wdata = '0;
    test_reset();
    test_write_read();
    test_both_reads();
    test_back_to_back();
    test_reset_mid();
    test_rd_lat3();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
